// File: rtl/count_step_decoder_pkg.sv
// Shared encodings for the count step decoder: FSM states and modulo-4 step codes.
package count_step_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_SKIP = 2'd2,
        STEP_DOWN = 2'd3
    } step_t;

    // Modulo-4 difference between the accepted count and the reference.
    function automatic step_t classify_step(input logic [1:0] acc_v, input logic [1:0] ref_v);
        logic [1:0] delta;
        delta = acc_v - ref_v;
        return step_t'(delta);
    endfunction

endpackage

// File: rtl/count_in_sync.sv
// Two-flop synchronizer for the asynchronous count input, with an optional
// stability filter built only when STEP_FILTER_EN is defined.
module count_in_sync
    import count_step_decoder_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] count_in,
    output logic [1:0] acc_val,
    output logic       acc_vld
);

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("count_in_sync: FILT_LEN must be in 1..15");
    end

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] vld_q;

    // vld_q marks when sync2_q holds a genuinely sampled value rather than reset zeros.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= count_in;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

`ifdef STEP_FILTER_EN
    localparam logic [3:0] FILT_N = 4'(FILT_LEN);

    logic [1:0] cand_q, cand_d;
    logic [1:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       acc_vld_q, acc_vld_d;

    // A candidate differing from the accepted value must repeat FILT_LEN times in a row.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        acc_vld_d = acc_vld_q;
        if (vld_q[1]) begin
            if (acc_vld_q && (sync2_q == acc_q)) begin
                cnt_d = 4'd0;
            end else begin
                if ((cnt_q != 4'd0) && (sync2_q == cand_q)) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cand_d = sync2_q;
                    cnt_d  = 4'd1;
                end
                if (cnt_d == FILT_N) begin
                    acc_d     = sync2_q;
                    acc_vld_d = 1'b1;
                    cnt_d     = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_q    <= 2'b00;
            acc_q     <= 2'b00;
            cnt_q     <= 4'd0;
            acc_vld_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            acc_vld_q <= acc_vld_d;
        end
    end

    assign acc_val = acc_q;
    assign acc_vld = acc_vld_q;
`else
    assign acc_val = sync2_q;
    assign acc_vld = vld_q[1];
`endif

endmodule

// File: rtl/count_step_decoder.sv
// Decodes a modulo-4 count into up/down step pulses and a running position.
// Define STEP_FILTER_EN to insert a FILT_LEN-cycle glitch filter after the synchronizer.
module count_step_decoder
    import count_step_decoder_pkg::*;
#(
    parameter int POS_W    = 8,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       count_in,
    input  logic             clr_err,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             err,
    output logic             locked,
    output logic [POS_W-1:0] position
);

    logic [1:0] acc_val;
    logic       acc_vld;

    count_in_sync #(
        .FILT_LEN(FILT_LEN)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .count_in(count_in),
        .acc_val (acc_val),
        .acc_vld (acc_vld)
    );

    state_t           state_q, state_d;
    logic [1:0]       ref_q, ref_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    step_t            step;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        pos_d   = pos_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = err_q;
        step    = classify_step(acc_val, ref_q);
        case (state_q)
            IDLE: begin
                if (acc_vld) begin
                    ref_d   = acc_val;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                case (step)
                    STEP_UP: begin
                        up_d  = 1'b1;
                        pos_d = pos_q + POS_W'(1);
                        ref_d = acc_val;
                    end
                    STEP_DOWN: begin
                        down_d = 1'b1;
                        pos_d  = pos_q - POS_W'(1);
                        ref_d  = acc_val;
                    end
                    // Direction of a two-step jump is unknowable; stop tracking.
                    STEP_SKIP: begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                    default: ;
                endcase
            end
            ERROR: begin
                err_d = 1'b1;
                if (clr_err) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ref_q    <= 2'b00;
            pos_q    <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            pos_q    <= pos_d;
            up_q     <= up_d;
            down_q   <= down_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign up_pulse   = up_q;
    assign down_pulse = down_q;
    assign err        = err_q;
    assign locked     = locked_q;
    assign position   = pos_q;

endmodule
